// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: produces enables/flushes for the PC and
// pipeline registers covering load-use, taken branches, data-memory waits and HLT drain.
module pipeline_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read_de,
    input  logic [3:0]       write_reg_de,
    input  logic [3:0]       rs_fd,
    input  logic [3:0]       rt_fd,
    input  logic             rs_used_fd,
    input  logic             rt_used_fd,
    input  logic             branch_taken,
    input  logic             hlt_fd,
    input  logic             mem_req_xm,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_xm,
    output logic             en_mw,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_mw,
    output logic             halted,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {StRun, StMemWait, StDrain, StHalted} state_e;

    localparam logic [8:0] TmoLim = 9'(MEM_TIMEOUT);
    localparam logic [7:0] DrnLim = 8'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [7:0]       drn_q, drn_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic pc_c, en_fd_c, en_de_c, en_xm_c, en_mw_c;
    logic flush_fd_c, flush_de_c, flush_mw_c, halted_c;
    logic mem_wait, load_use;
    logic [8:0] tmo_inc;

    assign mem_wait = mem_req_xm & ~mem_ready;
    assign load_use = mem_read_de & (write_reg_de != 4'd0) &
                      ((rs_used_fd & (rs_fd == write_reg_de)) |
                       (rt_used_fd & (rt_fd == write_reg_de)));
    assign tmo_inc  = {1'b0, tmo_q} + 9'd1;

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        drn_d      = drn_q;
        err_d      = err_q;
        pc_c       = 1'b1;
        en_fd_c    = 1'b1;
        en_de_c    = 1'b1;
        en_xm_c    = 1'b1;
        en_mw_c    = 1'b1;
        flush_fd_c = 1'b0;
        flush_de_c = 1'b0;
        flush_mw_c = 1'b0;
        halted_c   = 1'b0;
        case (state_q)
            StRun: begin
                if (mem_wait) begin
                    {pc_c, en_fd_c, en_de_c, en_xm_c} = 4'b0000;
                    flush_mw_c = 1'b1;
                    tmo_d      = 8'd1;
                    if (TmoLim <= 9'd1) begin
                        err_d   = 1'b1;
                        state_d = StHalted;
                    end else begin
                        state_d = StMemWait;
                    end
                end else if (load_use) begin
                    // Branch/HLT decisions wait until the stalled operands are valid.
                    pc_c       = 1'b0;
                    en_fd_c    = 1'b0;
                    flush_de_c = 1'b1;
                end else if (hlt_fd) begin
                    pc_c       = 1'b0;
                    flush_fd_c = 1'b1;
                    drn_d      = 8'd1;
                    state_d    = StDrain;
                end else if (branch_taken) begin
                    flush_fd_c = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_ready) begin
                    state_d = StRun;
                end else begin
                    {pc_c, en_fd_c, en_de_c, en_xm_c} = 4'b0000;
                    flush_mw_c = 1'b1;
                    if (tmo_inc >= TmoLim) begin
                        err_d   = 1'b1;
                        state_d = StHalted;
                    end else begin
                        tmo_d = tmo_inc[7:0];
                    end
                end
            end
            StDrain: begin
                pc_c = 1'b0;
                if (mem_wait) begin
                    {en_fd_c, en_de_c, en_xm_c} = 3'b000;
                    flush_mw_c = 1'b1;
                end else begin
                    flush_fd_c = 1'b1;
                    if (drn_q >= DrnLim) begin
                        state_d = StHalted;
                    end else begin
                        drn_d = drn_q + 8'd1;
                    end
                end
            end
            StHalted: begin
                {pc_c, en_fd_c, en_de_c, en_xm_c, en_mw_c} = 5'b00000;
                halted_c = 1'b1;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (((state_q == StRun) || (state_q == StMemWait)) && !pc_c && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            tmo_q   <= 8'd0;
            drn_q   <= 8'd0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            drn_q   <= drn_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign pc_en       = pc_c & ~rst;
    assign en_fd       = en_fd_c & ~rst;
    assign en_de       = en_de_c & ~rst;
    assign en_xm       = en_xm_c & ~rst;
    assign en_mw       = en_mw_c & ~rst;
    assign flush_fd    = flush_fd_c & ~rst;
    assign flush_de    = flush_de_c & ~rst;
    assign flush_mw    = flush_mw_c & ~rst;
    assign halted      = halted_c & ~rst;
    assign mem_error   = err_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: table-driven single-cycle vectors plus
// multi-cycle sequences, expected outputs queued at drive time and popped at sample time.
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_read_de, rs_used_fd, rt_used_fd, branch_taken, hlt_fd, mem_req_xm, mem_ready;
    logic [3:0] write_reg_de, rs_fd, rt_fd;

    logic        pc_en, en_fd, en_de, en_xm, en_mw, flush_fd, flush_de, flush_mw, halted, mem_error;
    logic [15:0] stall_count;
    logic        b_pc_en, b_en_fd, b_en_de, b_en_xm, b_en_mw;
    logic        b_flush_fd, b_flush_de, b_flush_mw, b_halted, b_mem_error;
    logic [1:0]  b_stall_count;

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut_a (
        .clk(clk), .rst(rst), .mem_read_de(mem_read_de), .write_reg_de(write_reg_de),
        .rs_fd(rs_fd), .rt_fd(rt_fd), .rs_used_fd(rs_used_fd), .rt_used_fd(rt_used_fd),
        .branch_taken(branch_taken), .hlt_fd(hlt_fd), .mem_req_xm(mem_req_xm),
        .mem_ready(mem_ready), .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .en_xm(en_xm),
        .en_mw(en_mw), .flush_fd(flush_fd), .flush_de(flush_de), .flush_mw(flush_mw),
        .halted(halted), .mem_error(mem_error), .stall_count(stall_count)
    );

    // Short timeout and a 2-bit counter to reach the timeout and saturation corners quickly.
    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .DRAIN_CYCLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .mem_read_de(mem_read_de), .write_reg_de(write_reg_de),
        .rs_fd(rs_fd), .rt_fd(rt_fd), .rs_used_fd(rs_used_fd), .rt_used_fd(rt_used_fd),
        .branch_taken(branch_taken), .hlt_fd(hlt_fd), .mem_req_xm(mem_req_xm),
        .mem_ready(mem_ready), .pc_en(b_pc_en), .en_fd(b_en_fd), .en_de(b_en_de),
        .en_xm(b_en_xm), .en_mw(b_en_mw), .flush_fd(b_flush_fd), .flush_de(b_flush_de),
        .flush_mw(b_flush_mw), .halted(b_halted), .mem_error(b_mem_error),
        .stall_count(b_stall_count)
    );

    typedef struct {
        logic       mr;
        logic [3:0] wr, rs, rt;
        logic       ru, tu, br, hl, mq, my;
        logic [8:0] exp;
    } vec_t;

    // {pc_en, en_fd, en_de, en_xm, en_mw, flush_fd, flush_de, flush_mw, halted}
    localparam logic [8:0] EnAll = 9'b11111_000_0;
    localparam logic [8:0] Stall = 9'b00111_010_0;
    localparam logic [8:0] Brnch = 9'b11111_100_0;
    localparam logic [8:0] Frz   = 9'b00001_001_0;
    localparam logic [8:0] Drain = 9'b01111_100_0;
    localparam logic [8:0] Halt  = 9'b00000_000_1;
    localparam logic [8:0] Zero  = 9'b00000_000_0;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] outs_a;
    vec_t       tbl[11];
    vec_t       v;

    assign outs_a = {pc_en, en_fd, en_de, en_xm, en_mw, flush_fd, flush_de, flush_mw, halted};

    function automatic vec_t mk(input logic mr, input logic [3:0] wr, input logic [3:0] rs,
                                input logic [3:0] rt, input logic ru, input logic tu,
                                input logic br, input logic hl, input logic mq, input logic my,
                                input logic [8:0] exp);
        vec_t r;
        r.mr = mr; r.wr = wr; r.rs = rs; r.rt = rt; r.ru = ru; r.tu = tu;
        r.br = br; r.hl = hl; r.mq = mq; r.my = my; r.exp = exp;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        mem_read_de = x.mr; write_reg_de = x.wr; rs_fd = x.rs; rt_fd = x.rt;
        rs_used_fd = x.ru; rt_used_fd = x.tu; branch_taken = x.br; hlt_fd = x.hl;
        mem_req_xm = x.mq; mem_ready = x.my;
    endtask

    // Drive one cycle of stimulus, then compare at the falling edge.
    task automatic step(input string nm, input vec_t x);
        apply(x);
        exp_q.push_back(x.exp);
        @(negedge clk);
        chk(nm, 32'(outs_a), 32'(exp_q.pop_front()));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Zero));
        @(negedge clk);
        chk("rst_outs", 32'(outs_a), 32'(Zero));
        chk("rst_stall_cnt", 32'(stall_count), 32'd0);
        chk("rst_mem_error_b", 32'(b_mem_error), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, EnAll);  // idle
        tbl[1]  = mk(1, 3, 1, 3, 0, 1, 0, 0, 0, 1, Stall);  // load r3, add reads r3 via rt
        tbl[2]  = mk(1, 5, 5, 2, 1, 1, 0, 0, 0, 1, Stall);  // match on rs
        tbl[3]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, EnAll);  // load to r0: no hazard
        tbl[4]  = mk(1, 3, 1, 3, 1, 0, 0, 0, 0, 1, EnAll);  // rt matches but unused
        tbl[5]  = mk(0, 3, 3, 3, 1, 1, 0, 0, 0, 1, EnAll);  // not a load
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, Brnch);  // taken branch
        tbl[7]  = mk(1, 7, 7, 0, 1, 0, 1, 0, 0, 1, Stall);  // load-use beats branch
        tbl[8]  = mk(0, 7, 7, 0, 1, 0, 1, 0, 0, 1, Brnch);  // squash on following cycle
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, EnAll);  // memory access ready at once
        tbl[10] = mk(1, 9, 9, 9, 1, 1, 0, 1, 0, 1, Stall);  // load-use beats hlt

        do_reset();
        for (int i = 0; i < 11; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
            tick();
        end
        chk("stall_cnt_after_vecs", 32'(stall_count), 32'd4);
        chk("stall_cnt_saturated_b", 32'(b_stall_count), 32'd3);

        // Five-cycle memory wait; hazard inputs injected mid-wait must be ignored.
        for (int i = 0; i < 5; i++) begin
            if (i == 2) v = mk(1, 3, 3, 3, 1, 1, 1, 1, 1, 0, Frz);
            else        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, Frz);
            step($sformatf("memwait%0d", i), v);
            if (i == 3) chk("b_not_halted_before_timeout", 32'(b_halted), 32'd0);
            if (i == 4) begin
                chk("b_halted_after_timeout", 32'(b_halted), 32'd1);
                chk("b_mem_error", 32'(b_mem_error), 32'd1);
                chk("b_pc_en_halted", 32'(b_pc_en), 32'd0);
            end
            tick();
        end
        step("memwait_ready", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, EnAll));
        tick();
        chk("stall_cnt_after_wait", 32'(stall_count), 32'd9);
        chk("a_mem_error_clear", 32'(mem_error), 32'd0);
        step("run_after_wait", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, Brnch));
        tick();

        // HLT drain with a memory wait inside; the wait must not advance the drain.
        do_reset();
        step("hlt_issue", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, Drain));
        tick();
        step("drain1", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, Drain));
        tick();
        step("drain_memwait", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, Frz));
        tick();
        step("drain2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Drain));
        tick();
        step("drain3", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Drain));
        tick();
        for (int i = 0; i < 3; i++) begin
            step($sformatf("halted%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, Halt));
            tick();
        end
        chk("stall_cnt_after_halt", 32'(stall_count), 32'd1);

        // Reset in the middle of a drain returns straight to RUN.
        do_reset();
        step("hlt_again", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, Drain));
        tick();
        step("drain_before_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Drain));
        tick();
        do_reset();
        step("run_after_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, EnAll));
        tick();
        chk("stall_cnt_after_rst", 32'(stall_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
